// File: rtl/risc16_pkg.sv
// Shared types and constants for the risc16 memory arbiter.
package risc16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam int FAIR_LIMIT_DEF = 4;

endpackage

// File: rtl/risc16_arb_pick.sv
// Winner selection between fetch and data ports.
// Build option: RISC16_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// otherwise data has priority, bounded by a fairness counter.
module risc16_arb_pick
   import risc16_pkg::*;
#(
   parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   if_req,
   input  logic   d_req,
   input  logic   grant,
   output owner_t pick
);

   localparam int CW = $clog2(FAIR_LIMIT + 1);

   owner_t          last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Combinational winner; only meaningful while at least one request is up.
   always_comb begin
      pick = OWN_IF;
      if (d_req && !if_req) begin
         pick = OWN_D;
      end else if (d_req && if_req) begin
`ifdef RISC16_ARB_ROUND_ROBIN_EN
         pick = (last_q == OWN_IF) ? OWN_D : OWN_IF;
`else
         pick = (cnt_q >= CW'(FAIR_LIMIT)) ? OWN_IF : OWN_D;
`endif
      end
   end

   // Track last winner and data grants taken while fetch was waiting.
   always_comb begin
      last_d = last_q;
      cnt_d  = cnt_q;
      if (grant) begin
         last_d = pick;
         if (pick == OWN_IF) begin
            cnt_d = '0;
         end else if (if_req && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Selection history registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_D;
         cnt_q  <= '0;
      end else begin
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single shared memory.
// Each transaction walks IDLE -> ACCESS -> RESP, one cycle each.
// Build option: RISC16_ARB_ROUND_ROBIN_EN (see risc16_arb_pick).
module risc16_mem_arbiter
   import risc16_pkg::*;
#(
   parameter int WORD_LENGTH = 16,
   parameter int FAIR_LIMIT  = FAIR_LIMIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_req,
   input  logic [WORD_LENGTH-1:0] if_addr,
   output logic                   if_ack,
   output logic [WORD_LENGTH-1:0] if_rdata,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [WORD_LENGTH-1:0] d_addr,
   input  logic [WORD_LENGTH-1:0] d_wdata,
   output logic                   d_ack,
   output logic [WORD_LENGTH-1:0] d_rdata,
   output logic [WORD_LENGTH-1:0] mem_addr,
   output logic [WORD_LENGTH-1:0] mem_wdata,
   output logic                   mem_we,
   input  logic [WORD_LENGTH-1:0] mem_rdata,
   output logic                   busy
);

   arb_state_t             state_q, state_d;
   owner_t                 owner_q, owner_d;
   logic [WORD_LENGTH-1:0] addr_q, addr_d;
   logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
   logic                   we_q, we_d;
   logic [WORD_LENGTH-1:0] if_rdata_q, if_rdata_d;
   logic [WORD_LENGTH-1:0] d_rdata_q, d_rdata_d;
   logic                   grant;
   owner_t                 pick;

   // Grants happen only from IDLE; RESP never re-grants.
   assign grant = (state_q == ST_IDLE) && (if_req || d_req);

   risc16_arb_pick #(.FAIR_LIMIT(FAIR_LIMIT)) u_pick (
      .clk    (clk),
      .rst    (rst),
      .if_req (if_req),
      .d_req  (d_req),
      .grant  (grant),
      .pick   (pick)
   );

   // Next-state and datapath latch logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant) begin
               owner_d = pick;
               state_d = ST_ACCESS;
               if (pick == OWN_D) begin
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  we_d    = d_we;
               end else begin
                  addr_d  = if_addr;
                  we_d    = 1'b0;
               end
            end
         end
         ST_ACCESS: begin
            if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
            else                   d_rdata_d  = mem_rdata;
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = (state_q == ST_ACCESS) && (owner_q == OWN_D) && we_q;
   assign if_ack    = (state_q == ST_RESP) && (owner_q == OWN_IF);
   assign d_ack     = (state_q == ST_RESP) && (owner_q == OWN_D);
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed self-checking bench for risc16_mem_arbiter with a byte memory model.
module tb_risc16_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ack;
   logic [15:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:65535];
   logic [15:0] mem_a1;

   always #5 clk = ~clk;

   risc16_mem_arbiter #(.WORD_LENGTH(16), .FAIR_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Big-endian byte-pair memory, written on negedge.
   assign mem_a1    = mem_addr + 16'd1;
   assign mem_rdata = {mem[mem_addr], mem[mem_a1]};
   always @(negedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata[15:8];
         mem[mem_a1]   <= mem_wdata[7:0];
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
      if_addr = 16'h1111; d_addr = 16'h2222; d_wdata = 16'h3333;
      rst = 1'b1;
      tick();
      // rst dominates the concurrent requests
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if ({if_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b want 00", {if_ack, d_ack}); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      checks++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0000/0000", mem_addr, mem_wdata); end
      checks++; if (if_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h/%h want 0000/0000", if_rdata, d_rdata); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_fetch;
      mem[16'h0010] = 8'hAB; mem[16'h0011] = 8'hCD;
      if_req = 1'b1; if_addr = 16'h0010;
      tick();
      checks++; if (busy !== 1'b1 || if_ack !== 1'b0) begin errors++; $display("FAIL fetch_access busy/ack got %b%b want 10", busy, if_ack); end
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL fetch_addr got %h want 0010", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we_access got %b want 0", mem_we); end
      tick();
      checks++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack got if=%b d=%b want if=1 d=0", if_ack, d_ack); end
      checks++; if (if_rdata !== 16'hABCD) begin errors++; $display("FAIL fetch_rdata got %h want abcd", if_rdata); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we_resp got %b want 0", mem_we); end
      if_req = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || if_ack !== 1'b0) begin errors++; $display("FAIL fetch_done busy/ack got %b%b want 00", busy, if_ack); end
   endtask

   task automatic test_store_load;
      int  we_cnt;
      bit  got;
      we_cnt = 0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (mem_we) we_cnt++;
         if (d_ack) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL store_ack got none want d_ack"); end
      d_req = 1'b0; d_we = 1'b0; d_wdata = 16'h0000;
      tick();
      d_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (mem_we) we_cnt++;
         if (d_ack) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL load_ack got none want d_ack"); end
      checks++; if (d_rdata !== 16'h1234) begin errors++; $display("FAIL load_rdata got %h want 1234", d_rdata); end
      checks++; if (we_cnt != 1) begin errors++; $display("FAIL store_we_cycles got %0d want 1", we_cnt); end
      d_req = 1'b0;
      tick();
   endtask

   task automatic test_tie;
`ifdef RISC16_ARB_ROUND_ROBIN_EN
      localparam int NT = 4;
`else
      localparam int NT = 10;
`endif
      bit exp_if, exp_any;
      do_reset();
      if_req = 1'b1; if_addr = 16'h0010;
      d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
      for (int c = 1; c <= 3 * NT; c++) begin
         tick();
         exp_any = ((c % 3) == 2);
`ifdef RISC16_ARB_ROUND_ROBIN_EN
         exp_if = exp_any && ((c / 3) % 2 == 0);
`else
         exp_if = exp_any && ((c / 3) % 5 == 4);
`endif
         checks++;
         if (if_ack !== exp_if || d_ack !== (exp_any && !exp_if)) begin
            errors++;
            $display("FAIL tie_acks cycle %0d got if=%b d=%b want if=%b d=%b", c, if_ack, d_ack, exp_if, exp_any && !exp_if);
         end
         if (exp_any) begin
            checks++;
            if (exp_if ? (if_rdata !== 16'hABCD) : (d_rdata !== 16'h1234)) begin
               errors++;
               $display("FAIL tie_rdata cycle %0d got if=%h d=%h", c, if_rdata, d_rdata);
            end
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5555;
      tick();
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL midrst_access_we got %b want 1", mem_we); end
      rst = 1'b1;
      tick();
      checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL midrst_abort we/busy/ack got %b%b%b want 000", mem_we, busy, d_ack); end
      rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
      tick();
      checks++; if (d_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after ack/busy got %b%b want 00", d_ack, busy); end
   endtask

   task automatic test_addr_wrap;
      mem[16'hFFFF] = 8'h9A; mem[16'h0000] = 8'hBC;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFFF;
      tick();
      checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr got %h want ffff", mem_addr); end
      tick();
      checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL wrap_ack got %b want 1", d_ack); end
      checks++; if (d_rdata !== 16'h9ABC) begin errors++; $display("FAIL wrap_rdata got %h want 9abc", d_rdata); end
      d_req = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      @(negedge clk);
      test_reset();
      test_fetch();
      test_store_load();
      test_tie();
      test_reset_mid();
      test_addr_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc16_mem_arbiter.md
RISC16_MEM_ARBITER -- requirements
Module: risc16_mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16: data and address width in bits.
REQ-002 SHALL have parameter FAIR_LIMIT, default 4: consecutive data grants allowed while fetch waits (fixed-priority build only).
REQ-003 SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port if_req, input, 1: instruction-fetch request, held until if_ack.
REQ-006 SHALL have port if_addr, input, WORD_LENGTH: fetch byte address.
REQ-007 SHALL have port if_ack, output, 1: one-cycle fetch completion pulse.
REQ-008 SHALL have port if_rdata, output, WORD_LENGTH: fetched word, valid while if_ack=1.
REQ-009 SHALL have port d_req, input, 1: data request, held until d_ack.
REQ-010 SHALL have port d_we, input, 1: 1=store, 0=load.
REQ-011 SHALL have port d_addr, input, WORD_LENGTH: data byte address.
REQ-012 SHALL have port d_wdata, input, WORD_LENGTH: store data.
REQ-013 SHALL have port d_ack, output, 1: one-cycle data completion pulse.
REQ-014 SHALL have port d_rdata, output, WORD_LENGTH: load word, valid while d_ack=1.
REQ-015 SHALL have port mem_addr, output, WORD_LENGTH: address to the shared memory.
REQ-016 SHALL have port mem_wdata, output, WORD_LENGTH: write data to the shared memory.
REQ-017 SHALL have port mem_we, output, 1: write enable to the shared memory, which writes on negedge.
REQ-018 SHALL have port mem_rdata, input, WORD_LENGTH: combinational big-endian word {byte[a], byte[a+1]} from memory.
REQ-019 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 SHALL implement states IDLE, ACCESS, RESP; owner register OWN_IF/OWN_D selects the granted port.
REQ-021 IDLE: if any request is high at posedge, latch the winner's address, data and we, set owner, and move to ACCESS; otherwise stay.
REQ-022 ACCESS (exactly one cycle): drive latched address and data; mem_we=1 only for a data store; at posedge capture mem_rdata into the owner's rdata register, go to RESP.
REQ-023 RESP (one cycle): pulse the owner's ack; return to IDLE; never grant in RESP, so back-to-back requests complete every 3 cycles.
REQ-024 Latency: request sampled at posedge N, ack high in cycle N+2.
REQ-025 mem_we SHALL be 0 in IDLE and RESP and for any load or fetch; mem_addr/mem_wdata hold their last values outside ACCESS.
REQ-026 Simultaneous if_req and d_req SHALL be resolved per Configuration; the loser stays pending without being dropped.
REQ-027 A request deasserted before its ack is a protocol violation; behaviour is undefined and the transaction still completes.
REQ-028 Address arithmetic wraps modulo 2^WORD_LENGTH; 0xFFFF is passed through unchanged, and byte-pair wrap is the memory's concern.
REQ-029 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-030 On rst at posedge: state=IDLE, owner=OWN_IF, if_ack=d_ack=0, mem_we=0, mem_addr=mem_wdata=0, if_rdata=d_rdata=0, busy=0, fairness counter=0, last-winner=OWN_D.
REQ-031 rst mid-transaction SHALL abort it with no ack; mem_we=0 from the next cycle.
REQ-032 rst dominates a concurrent request in the same cycle.

Configuration
REQ-033 Macro RISC16_ARB_ROUND_ROBIN_EN defined: on a tie, grant the port that did not win last; first tie after reset goes to fetch.
REQ-034 Macro absent: data has fixed priority, except fetch wins when the counter of consecutive data grants while if_req was pending reaches FAIR_LIMIT; the counter clears on any fetch grant.

Structure
REQ-035 State encodings, owner encodings and the FAIR_LIMIT default SHALL live in the shared package risc16_pkg.
REQ-036 Winner selection SHALL be a sub-module risc16_arb_pick (combinational pick plus last-winner/counter registers); the FSM stays in the top.

Verification
REQ-037 Single fetch: if_req, if_addr=0x0010, memory word 0xABCD -> if_ack in cycle N+2, if_rdata=0xABCD, mem_we never 1.
REQ-038 Store then load: d_we=1, d_addr=0x0020, d_wdata=0x1234, then load 0x0020 -> d_rdata=0x1234; mem_we high for exactly one cycle.
REQ-039 Tie, round-robin build: both requests held for 4 transactions -> acks alternate IF, D, IF, D, one every 3 cycles.
REQ-040 Tie, fixed build, FAIR_LIMIT=4: d_req and if_req held continuously -> 4 d_acks, then 1 if_ack, then the pattern repeats.
REQ-041 Reset in ACCESS of a store -> no d_ack, mem_we=0 from the next cycle, busy=0, state IDLE.
REQ-042 Address 0xFFFF load -> mem_addr=0xFFFF; d_ack is delivered normally.
